// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the register-read stage, the
// execute unit and write-back. The master modport is the environment side
// (producer of operands, consumer of results); the slave modport is alu_exec.
interface alu_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            ALUctrl;
  logic [DATA_WIDTH-1:0] ALUop1;
  logic [DATA_WIDTH-1:0] ALUop2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  EQ;
  logic                  busy;

  modport master (
    output in_valid, ALUctrl, ALUop1, ALUop2, out_ready,
    input  in_ready, out_valid, result, EQ, busy
  );

  modport slave (
    input  in_valid, ALUctrl, ALUop1, ALUop2, out_ready,
    output in_ready, out_valid, result, EQ, busy
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle execute unit: single-cycle ALU ops plus iterative shift-add
// multiply and restoring divide, behind a valid/ready handshake. The result
// and EQ flag are registered and held until the consumer takes them.
module alu_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [SHAMT_WIDTH-1:0] CNT_LAST = SHAMT_WIDTH'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU
  } op_e;

  typedef enum logic [1:0] {K_MUL, K_MULHU, K_DIVU, K_REMU} kind_e;

  state_e                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  // Multiply: {partial high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*W-1:0]         acc_q, acc_d;
  logic [W-1:0]           opb_q, opb_d;      // multiplicand or divisor
  kind_e                  kind_q, kind_d;
  logic [W-1:0]           result_q, result_d;
  logic                   eq_q, eq_d;
  logic                   eq_pend_q, eq_pend_d;

  logic                   in_ready_w;
  logic                   accept;
  logic [W:0]             mul_sum;
  logic [W:0]             rem_sh;
  logic [W:0]             diff;
  logic [2*W-1:0]         step_acc;

  function automatic logic [W-1:0] single_op(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [SHAMT_WIDTH-1:0] shamt;
    shamt = b[SHAMT_WIDTH-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: return {{(W-1){1'b0}}, (a < b)};
      OP_SLL:  return a << shamt;
      OP_SRL:  return a >> shamt;
      OP_SRA:  return $unsigned($signed(a) >>> shamt);
      default: return '0;
    endcase
  endfunction

  // Synchronous reset must also block acceptance in the reset cycle itself.
  assign in_ready_w = (state_q == S_IDLE) && !rst;
  assign accept     = bus.in_valid && in_ready_w;

  // One iteration of the multiply or divide datapath.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = rem_sh - {1'b0, opb_q};
    if (kind_q == K_MUL || kind_q == K_MULHU)
      step_acc = {mul_sum, acc_q[W-1:1]};
    else if (!diff[W])
      step_acc = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    else
      step_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
  end

  // Next-state and datapath update for the IDLE/CALC/DONE controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    kind_d    = kind_q;
    result_d  = result_q;
    eq_d      = eq_q;
    eq_pend_d = eq_pend_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.ALUctrl inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU}) begin
            state_d   = S_CALC;
            cnt_d     = CNT_LAST;
            acc_d     = {{W{1'b0}}, bus.ALUop1};
            opb_d     = bus.ALUop2;
            eq_pend_d = (bus.ALUop1 == bus.ALUop2);
            case (bus.ALUctrl)
              OP_MUL:   kind_d = K_MUL;
              OP_MULHU: kind_d = K_MULHU;
              OP_DIVU:  kind_d = K_DIVU;
              default:  kind_d = K_REMU;
            endcase
          end else begin
            state_d  = S_DONE;
            result_d = single_op(bus.ALUctrl, bus.ALUop1, bus.ALUop2);
            eq_d     = (bus.ALUop1 == bus.ALUop2);
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
          eq_d    = eq_pend_q;
          // Low half holds the product low bits / quotient, high half the
          // product high bits / remainder.
          if (kind_q == K_MUL || kind_q == K_DIVU)
            result_d = step_acc[W-1:0];
          else
            result_d = step_acc[2*W-1:W];
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      kind_q    <= K_MUL;
      result_q  <= '0;
      eq_q      <= 1'b0;
      eq_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      kind_q    <= kind_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      eq_pend_q <= eq_pend_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_CALC);
  assign bus.result    = result_q;
  assign bus.EQ        = eq_q;
endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec: a 32-bit instance for most scenarios and
// an 8-bit instance for the narrow-width multiply/divide latency.
module tb_alu_exec;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                         XOR_ = 4'd4, SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7,
                         SRL = 4'd8, SRA = 4'd9, MUL = 4'd10, MULHU = 4'd11,
                         DIVU = 4'd12, REMU = 4'd13;

  alu_exec_if #(.DATA_WIDTH(32)) bus ();
  alu_exec_if #(.DATA_WIDTH(8))  bus8 ();

  alu_exec #(.DATA_WIDTH(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_exec #(.DATA_WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one bundle on the 32-bit unit and wait (bounded) for its result.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic eq, output int lat,
                        output int busy_cyc, output logic rdy_seen);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    bus.ALUctrl = c; bus.ALUop1 = a; bus.ALUop2 = b; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ALUop1 = $urandom(); bus.ALUop2 = $urandom(); bus.ALUctrl = 4'($urandom());
    lat = 1; busy_cyc = 0; rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_cyc++;
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    res = bus.result;
    eq  = bus.EQ;
  endtask

  // Same as run_op for the 8-bit unit.
  task automatic run_op8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output int lat);
    int n;
    n = 0;
    while (!bus8.in_ready && n < 200) begin tick(); n++; end
    bus8.ALUctrl = c; bus8.ALUop1 = a; bus8.ALUop2 = b; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    bus8.ALUop1 = 8'($urandom()); bus8.ALUop2 = 8'($urandom());
    lat = 1;
    while (!bus8.out_valid && lat < 200) begin tick(); lat++; end
    res = bus8.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.ALUctrl = ADD; bus.ALUop1 = 32'd1; bus.ALUop2 = 32'd1;
    tick(); tick();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", bus.result); end
    tests++; if (bus.EQ !== 1'b0) begin fails++; $display("FAIL reset_eq: got %b want 0", bus.EQ); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add_sub();
    logic [31:0] r; logic e; int lat, bc; logic rs;
    run_op(ADD, 32'h7FFF_FFFF, 32'h1, r, e, lat, bc, rs);
    tests++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL add_result: got %h want 80000000", r); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL add_eq: got %b want 0", e); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency: got %0d want 1", lat); end
    run_op(SUB, 32'd5, 32'd5, r, e, lat, bc, rs);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL sub_result: got %h want 0", r); end
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL sub_eq: got %b want 1", e); end
  endtask

  task automatic test_shift_cmp();
    logic [3:0]  c [11] = '{AND_, OR_, XOR_, SLL, SRL, SRA, SLT, SLTU, SLT, SLTU, 4'd14};
    logic [31:0] a [11] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555, 32'h1, 32'h80000000,
                            32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h12345678};
    logic [31:0] b [11] = '{32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000, 32'h3F, 32'h4,
                            32'h24, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] x [11] = '{32'hF000F000, 32'hFFFFF0F0, 32'h55555555, 32'h80000000, 32'h08000000,
                            32'hF8000000, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0};
    logic [31:0] r; logic e; int lat, bc; logic rs;
    for (int i = 0; i < 11; i++) begin
      run_op(c[i], a[i], b[i], r, e, lat, bc, rs);
      tests++; if (r !== x[i]) begin fails++; $display("FAIL single_op[%0d] op=%0d: got %h want %h", i, c[i], r, x[i]); end
      tests++; if (e !== (a[i] == b[i])) begin fails++; $display("FAIL single_eq[%0d]: got %b want %b", i, e, a[i] == b[i]); end
    end
  endtask

  task automatic test_mul();
    logic [3:0]  c [6] = '{MUL, MULHU, MUL, MULHU, MUL, MULHU};
    logic [31:0] a [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h00010000, 32'h00010000};
    logic [31:0] b [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h00010000, 32'h00010000};
    logic [31:0] x [6] = '{32'h1, 32'hFFFFFFFE, 32'hA3D70A38, 32'h0, 32'h0, 32'h1};
    logic [31:0] r; logic e; int lat, bc; logic rs;
    for (int i = 0; i < 6; i++) begin
      run_op(c[i], a[i], b[i], r, e, lat, bc, rs);
      tests++; if (r !== x[i]) begin fails++; $display("FAIL mul[%0d] op=%0d: got %h want %h", i, c[i], r, x[i]); end
      tests++; if (e !== (a[i] == b[i])) begin fails++; $display("FAIL mul_eq[%0d]: got %b want %b", i, e, a[i] == b[i]); end
      tests++; if (lat !== 33) begin fails++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat); end
      tests++; if (bc !== 32) begin fails++; $display("FAIL mul_busy_cycles[%0d]: got %0d want 32", i, bc); end
      tests++; if (rs !== 1'b0) begin fails++; $display("FAIL mul_in_ready_during_calc[%0d]: got %b want 0", i, rs); end
    end
  endtask

  task automatic test_div();
    logic [3:0]  c [8] = '{DIVU, REMU, DIVU, REMU, DIVU, REMU, DIVU, REMU};
    logic [31:0] a [8] = '{32'd100, 32'd100, 32'hDEADBEEF, 32'h1234, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b [8] = '{32'd7, 32'd7, 32'h0, 32'h0, 32'd100, 32'd100, 32'h10, 32'h10};
    logic [31:0] x [8] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'h1234, 32'd0, 32'd7, 32'h0FFFFFFF, 32'hF};
    logic [31:0] r; logic e; int lat, bc; logic rs;
    for (int i = 0; i < 8; i++) begin
      run_op(c[i], a[i], b[i], r, e, lat, bc, rs);
      tests++; if (r !== x[i]) begin fails++; $display("FAIL div[%0d] op=%0d: got %h want %h", i, c[i], r, x[i]); end
      tests++; if (lat !== 33) begin fails++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic e; int lat, bc; logic rs;
    bus.out_ready = 1'b0;
    run_op(MUL, 32'd3, 32'd5, r, e, lat, bc, rs);
    tests++; if (r !== 32'd15) begin fails++; $display("FAIL bp_mul_result: got %h want f", r); end
    bus.ALUctrl = ADD; bus.ALUop1 = 32'd1; bus.ALUop2 = 32'd2; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd15 || bus.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b result=%h in_ready=%b want 1/f/0",
                 i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin
      fails++; $display("FAIL bp_second: got out_valid=%b result=%h want 1/3", bus.out_valid, bus.result); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cnt, first, second;
    bus.ALUctrl = ADD; bus.ALUop1 = 32'd10; bus.ALUop2 = 32'd20; bus.in_valid = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin tick(); if (bus.out_valid) cnt++; end
    bus.in_valid = 1'b0;
    tests++; if (cnt !== 4) begin fails++; $display("FAIL b2b_single_count: got %0d want 4", cnt); end
    tests++; if (bus.result !== 32'd30) begin fails++; $display("FAIL b2b_single_result: got %h want 1e", bus.result); end
    bus.ALUctrl = MUL; bus.ALUop1 = 32'd7; bus.ALUop2 = 32'd6; bus.in_valid = 1'b1;
    cnt = 0; first = 0; second = 0;
    for (int k = 1; k <= 68; k++) begin
      tick();
      if (bus.out_valid) begin
        if (cnt == 0) first = k; else second = k;
        cnt++;
      end
    end
    bus.in_valid = 1'b0;
    tests++; if (cnt !== 2) begin fails++; $display("FAIL b2b_iter_count: got %0d want 2", cnt); end
    tests++; if (first !== 33) begin fails++; $display("FAIL b2b_iter_first: got %0d want 33", first); end
    tests++; if (second - first !== 34) begin fails++; $display("FAIL b2b_iter_spacing: got %0d want 34", second - first); end
    tests++; if (bus.result !== 32'd42) begin fails++; $display("FAIL b2b_iter_result: got %h want 2a", bus.result); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; int lat, bc; logic rs; int n; int seen;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    bus.ALUctrl = DIVU; bus.ALUop1 = 32'd100; bus.ALUop2 = 32'd7; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL midrst_result: got %h want 0", bus.result); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (bus.out_valid) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
    run_op(ADD, 32'd2, 32'd3, r, e, lat, bc, rs);
    tests++; if (r !== 32'd5 || lat !== 1) begin fails++; $display("FAIL midrst_next_add: got %h lat %0d want 5 lat 1", r, lat); end
  endtask

  task automatic test_width8();
    logic [3:0] c [5] = '{MUL, MULHU, DIVU, REMU, DIVU};
    logic [7:0] a [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
    logic [7:0] b [5] = '{8'h02, 8'h02, 8'h10, 8'h10, 8'h00};
    logic [7:0] x [5] = '{8'hFE, 8'h01, 8'h0F, 8'h0F, 8'hFF};
    logic [7:0] r; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op8(c[i], a[i], b[i], r, lat);
      tests++; if (r !== x[i]) begin fails++; $display("FAIL w8[%0d] op=%0d: got %h want %h", i, c[i], r, x[i]); end
      tests++; if (lat !== 9) begin fails++; $display("FAIL w8_latency[%0d]: got %0d want 9", i, lat); end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.ALUctrl = 4'd0; bus.ALUop1 = '0; bus.ALUop2 = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.ALUctrl = 4'd0; bus8.ALUop1 = '0; bus8.ALUop2 = '0; bus8.out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_shift_cmp();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
